// File: rtl/eth_mdio_master.sv
// Clause 22 MDIO management master: serialises one 64-bit frame per request
// and returns read data plus a no-PHY error flag.
module eth_mdio_master #(
  parameter int ClkDiv      = 25,
  parameter int PreambleLen = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [4:0]  req_phy_addr_i,
  input  logic [4:0]  req_reg_addr_i,
  input  logic [15:0] req_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [15:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        busy_o,
  output logic        phy_mdc_o,
  input  logic        phy_mdio_i,
  output logic        phy_mdio_o,
  output logic        phy_mdio_oe_o
);

  localparam int DivW = $clog2(2 * ClkDiv);
  localparam logic [DivW-1:0] DivHalf   = DivW'(ClkDiv);
  localparam logic [DivW-1:0] DivSample = DivW'(ClkDiv - 1);
  localparam logic [DivW-1:0] DivLast   = DivW'(2 * ClkDiv - 1);
  localparam logic [5:0]      RdOeLast  = 6'd18;

  if (ClkDiv < 2) begin : g_bad_clkdiv
    $error("eth_mdio_master: ClkDiv must be >= 2");
  end
  if (PreambleLen != 32) begin : g_bad_preamble
    $error("eth_mdio_master: PreambleLen must be 32 for Clause 22 frames");
  end

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    RESP
  } state_e;

  state_e            state_q;
  logic [63:0]       frame_q;
  logic              write_q;
  logic [5:0]        bit_cnt_q;
  logic [DivW-1:0]   div_cnt_q;

  logic [63:0]       req_frame;
  logic              div_wrap;
  logic [DivW-1:0]   div_nxt;
  logic [5:0]        bit_nxt;

  // Read frames carry 1s in the released TA/data slots so the idle pad level is kept.
  always_comb begin
    if (req_write_i) begin
      req_frame = {{PreambleLen{1'b1}}, 2'b01, 2'b01, req_phy_addr_i, req_reg_addr_i,
                   2'b10, req_wdata_i};
    end else begin
      req_frame = {{PreambleLen{1'b1}}, 2'b01, 2'b10, req_phy_addr_i, req_reg_addr_i,
                   2'b11, 16'hFFFF};
    end
  end

  assign div_wrap = (div_cnt_q == DivLast);
  assign div_nxt  = div_wrap ? '0 : div_cnt_q + DivW'(1);
  assign bit_nxt  = bit_cnt_q - 6'd1;

  // NOTE: every register below uses non-blocking assignment so all updates
  // within one edge see the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      frame_q       <= '0;
      write_q       <= 1'b0;
      bit_cnt_q     <= '0;
      div_cnt_q     <= '0;
      req_ready_o   <= 1'b1;
      rsp_valid_o   <= 1'b0;
      rsp_rdata_o   <= '0;
      rsp_err_o     <= 1'b0;
      busy_o        <= 1'b0;
      phy_mdc_o     <= 1'b0;
      phy_mdio_o    <= 1'b1;
      phy_mdio_oe_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            frame_q       <= req_frame;
            write_q       <= req_write_i;
            bit_cnt_q     <= 6'd63;
            div_cnt_q     <= '0;
            rsp_rdata_o   <= '0;
            rsp_err_o     <= 1'b0;
            req_ready_o   <= 1'b0;
            busy_o        <= 1'b1;
            phy_mdio_o    <= req_frame[63];
            phy_mdio_oe_o <= 1'b1;
            state_q       <= SHIFT;
          end
        end

        SHIFT: begin
          div_cnt_q <= div_nxt;
          phy_mdc_o <= (div_nxt >= DivHalf);
          // Sample on the last low cycle so the value is the one seen at MDC rise.
          if (div_cnt_q == DivSample && !write_q) begin
            if (bit_cnt_q == 6'd16) begin
              rsp_err_o <= phy_mdio_i;
            end else if (bit_cnt_q < 6'd16) begin
              rsp_rdata_o <= {rsp_rdata_o[14:0], phy_mdio_i};
            end
          end
          if (div_wrap) begin
            if (bit_cnt_q == 6'd0) begin
              phy_mdio_o    <= 1'b1;
              phy_mdio_oe_o <= 1'b0;
              state_q       <= RESP;
            end else begin
              bit_cnt_q     <= bit_nxt;
              phy_mdio_o    <= frame_q[bit_nxt];
              phy_mdio_oe_o <= write_q || (bit_nxt >= RdOeLast);
            end
          end
        end

        RESP: begin
          if (!rsp_valid_o) begin
            rsp_valid_o <= 1'b1;
          end else if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            req_ready_o <= 1'b1;
            state_q     <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_mdio_master.sv
// Randomised bench for eth_mdio_master: a pad/PHY model drives MDIO and the
// frame seen on MDC rising edges is compared with one built from the frame rules.
module tb_eth_mdio_master;

  localparam int Div     = 2;
  localparam int Lat     = 128 * Div + 1;
  localparam int SlowDiv = 25;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Fast instance
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [4:0]  req_phy_addr_i, req_reg_addr_i;
  logic [15:0] req_wdata_i;
  logic        rsp_valid_o, rsp_ready_i, rsp_err_o, busy_o;
  logic [15:0] rsp_rdata_o;
  logic        phy_mdc_o, phy_mdio_i, phy_mdio_o, phy_mdio_oe_o;

  eth_mdio_master #(.ClkDiv(Div)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_phy_addr_i(req_phy_addr_i), .req_reg_addr_i(req_reg_addr_i), .req_wdata_i(req_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .busy_o(busy_o), .phy_mdc_o(phy_mdc_o),
    .phy_mdio_i(phy_mdio_i), .phy_mdio_o(phy_mdio_o), .phy_mdio_oe_o(phy_mdio_oe_o)
  );

  // Default-divider instance, no PHY attached (pad pulled up)
  logic        s_req_valid_i, s_req_ready_o, s_req_write_i;
  logic [4:0]  s_req_phy_addr_i, s_req_reg_addr_i;
  logic [15:0] s_req_wdata_i;
  logic        s_rsp_valid_o, s_rsp_ready_i, s_rsp_err_o, s_busy_o;
  logic [15:0] s_rsp_rdata_o;
  logic        s_phy_mdc_o, s_phy_mdio_i, s_phy_mdio_o, s_phy_mdio_oe_o;

  assign s_phy_mdio_i = s_phy_mdio_oe_o ? s_phy_mdio_o : 1'b1;

  eth_mdio_master dut_slow (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(s_req_valid_i), .req_ready_o(s_req_ready_o), .req_write_i(s_req_write_i),
    .req_phy_addr_i(s_req_phy_addr_i), .req_reg_addr_i(s_req_reg_addr_i),
    .req_wdata_i(s_req_wdata_i),
    .rsp_valid_o(s_rsp_valid_o), .rsp_ready_i(s_rsp_ready_i), .rsp_rdata_o(s_rsp_rdata_o),
    .rsp_err_o(s_rsp_err_o), .busy_o(s_busy_o), .phy_mdc_o(s_phy_mdc_o),
    .phy_mdio_i(s_phy_mdio_i), .phy_mdio_o(s_phy_mdio_o), .phy_mdio_oe_o(s_phy_mdio_oe_o)
  );

  // Pad and PHY model: rise_cnt counts MDC rising edges of the current frame.
  int          rise_cnt = 0;
  logic        mdc_prev = 1'b0;
  logic [63:0] cap_pad, cap_oe;
  logic        phy_present;
  logic [15:0] phy_data;

  function automatic logic phy_bit(input int nb, input logic present, input logic [15:0] data);
    if (!present) return 1'b1;
    if (nb == 16) return 1'b0;
    if (nb >= 0 && nb <= 15) return data[nb];
    return 1'b1;
  endfunction

  assign phy_mdio_i = phy_mdio_oe_o ? phy_mdio_o
                                    : phy_bit(63 - rise_cnt, phy_present, phy_data);

  always @(negedge clk_i) begin
    mdc_prev <= phy_mdc_o;
    if (rst_i || !busy_o) begin
      rise_cnt <= 0;
    end else if (phy_mdc_o && !mdc_prev && rise_cnt < 64) begin
      cap_pad[63-rise_cnt] <= phy_mdio_i;
      cap_oe[63-rise_cnt]  <= phy_mdio_oe_o;
      rise_cnt             <= rise_cnt + 1;
    end
  end

  function automatic logic [63:0] exp_pad(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                                          input logic [15:0] wd, input logic present,
                                          input logic [15:0] rd);
    if (wr) return {32'hFFFF_FFFF, 2'b01, 2'b01, pa, ra, 2'b10, wd};
    return {32'hFFFF_FFFF, 2'b01, 2'b10, pa, ra, 1'b1, !present, present ? rd : 16'hFFFF};
  endfunction

  // Called at a negedge; returns the cycle stamp of the accepting edge.
  task automatic send_req(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                          input logic [15:0] wd, output int acc);
    int w = 0;
    req_valid_i = 1'b1; req_write_i = wr;
    req_phy_addr_i = pa; req_reg_addr_i = ra; req_wdata_i = wd;
    while (!req_ready_o && w < 4 * Lat) begin
      @(negedge clk_i);
      w++;
    end
    check("req_ready_wait", req_ready_o, 1'b1);
    @(negedge clk_i);
    acc = cyc;
    req_valid_i = 1'b0;
  endtask

  task automatic wait_rsp(input int acc);
    int w = 0;
    while (!rsp_valid_o && w < 4 * Lat) begin
      @(negedge clk_i);
      w++;
    end
    check("rsp_valid_seen", rsp_valid_o, 1'b1);
    check("latency", 64'(cyc - acc), 64'(Lat));
  endtask

  task automatic check_frame(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                             input logic [15:0] wd, input logic present, input logic [15:0] rd);
    check("mdc_rises", 64'(rise_cnt), 64'd64);
    check("pad_frame", cap_pad, exp_pad(wr, pa, ra, wd, present, rd));
    check("oe_frame", cap_oe, wr ? {64{1'b1}} : {{46{1'b1}}, 18'h0});
  endtask

  task automatic hold_and_ack(input int hold, input logic [15:0] erd, input logic eerr);
    repeat (hold) begin
      @(negedge clk_i);
      check("hold_valid", rsp_valid_o, 1'b1);
      check("hold_rdata", rsp_rdata_o, erd);
      check("hold_err", rsp_err_o, eerr);
      check("hold_req_ready", req_ready_o, 1'b0);
      check("hold_mdc", phy_mdc_o, 1'b0);
    end
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    check("rsp_drop", rsp_valid_o, 1'b0);
    check("ready_back", req_ready_o, 1'b1);
    check("busy_clear", busy_o, 1'b0);
  endtask

  task automatic do_txn(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic present, input logic [15:0] rd,
                        input int hold);
    int acc;
    logic [15:0] erd;
    phy_present = present;
    phy_data    = rd;
    erd = wr ? 16'h0 : (present ? rd : 16'hFFFF);
    send_req(wr, pa, ra, wd, acc);
    check("busy_shift", busy_o, 1'b1);
    wait_rsp(acc);
    check_frame(wr, pa, ra, wd, present, rd);
    check("rsp_rdata", rsp_rdata_o, erd);
    check("rsp_err", rsp_err_o, !wr && !present);
    hold_and_ack(hold, erd, !wr && !present);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, acc2, w, r1, f1, r2;
    logic seen;
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_write_i = 1'b0; req_phy_addr_i = '0; req_reg_addr_i = '0;
    req_wdata_i = '0; rsp_ready_i = 1'b0;
    s_req_valid_i = 1'b0; s_req_write_i = 1'b0; s_req_phy_addr_i = '0; s_req_reg_addr_i = '0;
    s_req_wdata_i = '0; s_rsp_ready_i = 1'b0;
    phy_present = 1'b1; phy_data = '0;
    repeat (3) @(negedge clk_i);
    check("rst_mdc", phy_mdc_o, 1'b0);
    check("rst_mdio", phy_mdio_o, 1'b1);
    check("rst_oe", phy_mdio_oe_o, 1'b0);
    check("rst_rsp_valid", rsp_valid_o, 1'b0);
    check("rst_rdata", rsp_rdata_o, 16'h0);
    check("rst_err", rsp_err_o, 1'b0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_req_ready", req_ready_o, 1'b1);
    rst_i = 1'b0;
    @(negedge clk_i);

    // Directed frames
    do_txn(1'b1, 5'd1, 5'd0, 16'h1140, 1'b1, 16'h0, 0);
    do_txn(1'b0, 5'd7, 5'd2, 16'h0, 1'b1, 16'hBEEF, 1);
    do_txn(1'b0, 5'd3, 5'd1, 16'h0, 1'b0, 16'h0, 2);

    // Response held with a second request waiting
    phy_present = 1'b1; phy_data = 16'hA5C3;
    send_req(1'b0, 5'd9, 5'd17, 16'h0, acc);
    wait_rsp(acc);
    check("held_rdata", rsp_rdata_o, 16'hA5C3);
    req_valid_i = 1'b1; req_write_i = 1'b1;
    req_phy_addr_i = 5'd2; req_reg_addr_i = 5'd4; req_wdata_i = 16'h0F0F;
    hold_and_ack(10, 16'hA5C3, 1'b0);
    send_req(1'b1, 5'd2, 5'd4, 16'h0F0F, acc2);
    check("b2b_spacing", 64'(acc2 - acc), 64'(128 * Div + 3 + 10));
    wait_rsp(acc2);
    check_frame(1'b1, 5'd2, 5'd4, 16'h0F0F, 1'b1, 16'h0);
    check("b2b_rdata", rsp_rdata_o, 16'h0);
    hold_and_ack(0, 16'h0, 1'b0);

    // Reset in the middle of a read at bit 40
    phy_present = 1'b1; phy_data = 16'h5555;
    send_req(1'b0, 5'd3, 5'd4, 16'h0, acc);
    w = 0;
    while (rise_cnt < 24 && w < 4 * Lat) begin
      @(negedge clk_i);
      w++;
    end
    check("reach_bit40", 64'(rise_cnt), 64'd24);
    #1 rst_i = 1'b1;
    #1;
    check("arst_mdc", phy_mdc_o, 1'b0);
    check("arst_mdio", phy_mdio_o, 1'b1);
    check("arst_oe", phy_mdio_oe_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_req_ready", req_ready_o, 1'b1);
    check("arst_rsp_valid", rsp_valid_o, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0;
    seen = 1'b0;
    repeat (2 * Lat) begin
      @(negedge clk_i);
      if (rsp_valid_o || busy_o) seen = 1'b1;
    end
    check("no_rsp_after_abort", seen, 1'b0);
    do_txn(1'b0, 5'd5, 5'd6, 16'h0, 1'b1, 16'h1234, 0);

    // Random traffic
    for (int i = 0; i < 12; i++) begin
      logic wr, present;
      logic [4:0] pa, ra;
      logic [15:0] wd, rd;
      wr      = 1'($urandom_range(0, 1));
      present = ($urandom_range(0, 3) != 0);
      pa      = 5'($urandom);
      ra      = 5'($urandom);
      wd      = 16'($urandom);
      rd      = 16'($urandom);
      do_txn(wr, pa, ra, wd, present, rd, int'($urandom_range(0, 3)));
    end

    // Default divider: MDC timing and latency, read with no PHY
    s_req_valid_i = 1'b1; s_req_write_i = 1'b0;
    s_req_phy_addr_i = 5'd4; s_req_reg_addr_i = 5'd3;
    w = 0;
    while (!s_req_ready_o && w < 100) begin
      @(negedge clk_i);
      w++;
    end
    @(negedge clk_i);
    acc = cyc;
    s_req_valid_i = 1'b0;
    w = 0;
    while (!s_phy_mdc_o && w < 400) begin @(negedge clk_i); w++; end
    r1 = cyc;
    w = 0;
    while (s_phy_mdc_o && w < 400) begin @(negedge clk_i); w++; end
    f1 = cyc;
    w = 0;
    while (!s_phy_mdc_o && w < 400) begin @(negedge clk_i); w++; end
    r2 = cyc;
    check("slow_mdc_high", 64'(f1 - r1), 64'(SlowDiv));
    check("slow_mdc_period", 64'(r2 - r1), 64'(2 * SlowDiv));
    w = 0;
    while (!s_rsp_valid_o && w < 8000) begin @(negedge clk_i); w++; end
    check("slow_rsp_seen", s_rsp_valid_o, 1'b1);
    check("slow_latency", 64'(cyc - acc), 64'(128 * SlowDiv + 1));
    check("slow_rdata", s_rsp_rdata_o, 16'hFFFF);
    check("slow_err", s_rsp_err_o, 1'b1);
    s_rsp_ready_i = 1'b1;
    @(negedge clk_i);
    s_rsp_ready_i = 1'b0;
    check("slow_rsp_drop", s_rsp_valid_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
